// File: rtl/flit_source_sched.sv
// Credit-based flit source: round-robin packet scheduling over VCs, whole
// packets per VC, one bubble after each tail, sticky credit-overflow flag.
module flit_source_sched #(
    parameter int num_vcs            = 8,
    parameter int buffer_size        = 64,
    parameter int max_payload_length = 4,
    parameter int min_payload_length = 1,
    localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
    localparam int len_width    = (max_payload_length - min_payload_length + 1 > 1) ?
                                  $clog2(max_payload_length - min_payload_length + 1) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_vcs-1:0]             pkt_req_ivc,
    input  logic [num_vcs*len_width-1:0]   pkt_len_ivc,
    input  logic [vc_idx_width:0]          flow_ctrl_in,
    output logic                           flit_valid_out,
    output logic                           flit_head_out,
    output logic                           flit_tail_out,
    output logic [num_vcs-1:0]             flit_sel_ivc,
    output logic [num_vcs-1:0]             pkt_done_ivc,
    output logic                           error
);
    localparam int CPV = buffer_size / num_vcs;
    localparam int CW  = $clog2(CPV + 1);
    localparam int RW  = (max_payload_length > 0) ? $clog2(max_payload_length + 1) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q [num_vcs];
    logic [vc_idx_width-1:0] rr_q, cur_q, win;
    logic [RW-1:0]           rem_q, len_w;
    logic                    valid_q, head_q, tail_q, err_q;
    logic [num_vcs-1:0]      sel_q, done_q;

    logic [num_vcs-1:0]      elig, win_oh, cur_oh, ret_hit, iss_hit;
    logic [len_width-1:0]    code_w;
    logic                    idle_go, send_go;

    always_comb begin
        for (int i = 0; i < num_vcs; i++)
            elig[i] = pkt_req_ivc[i] && (cnt_q[i] != '0);
    end

    // Scan downward so the VC closest to rr_q wins.
    always_comb begin
        win = '0;
        for (int k = num_vcs - 1; k >= 0; k--) begin
            if (elig[(int'(rr_q) + k) % num_vcs])
                win = vc_idx_width'((int'(rr_q) + k) % num_vcs);
        end
    end

    assign code_w  = pkt_len_ivc[int'(win)*len_width +: len_width];
    assign len_w   = RW'(int'(code_w) + min_payload_length);
    assign win_oh  = num_vcs'(1) << win;
    assign cur_oh  = num_vcs'(1) << cur_q;

    // tail_q blocks selection in the tail cycle, giving the turnaround bubble.
    assign idle_go = (state_q == IDLE) && !tail_q && (|elig);
    assign send_go = (state_q == SEND) && (rem_q != '0) && (cnt_q[cur_q] != '0);

    always_comb begin
        ret_hit = flow_ctrl_in[0] ? (num_vcs'(1) << flow_ctrl_in[vc_idx_width:1]) : '0;
        iss_hit = idle_go ? win_oh : (send_go ? cur_oh : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            sel_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < num_vcs; i++) cnt_q[i] <= CW'(CPV);
        end else begin
            valid_q <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            sel_q   <= '0;
            done_q  <= '0;
            if (idle_go) begin
                valid_q <= 1'b1;
                head_q  <= 1'b1;
                sel_q   <= win_oh;
                cur_q   <= win;
                rr_q    <= vc_idx_width'((int'(win) + 1) % num_vcs);
                rem_q   <= len_w;
                if (len_w == '0) begin
                    tail_q <= 1'b1;
                    done_q <= win_oh;
                end else begin
                    state_q <= SEND;
                end
            end else if (send_go) begin
                valid_q <= 1'b1;
                sel_q   <= cur_oh;
                rem_q   <= rem_q - RW'(1);
                if (rem_q == RW'(1)) begin
                    tail_q  <= 1'b1;
                    done_q  <= cur_oh;
                    state_q <= IDLE;
                end
            end
            for (int i = 0; i < num_vcs; i++) begin
                if (ret_hit[i] && !iss_hit[i]) begin
                    if (cnt_q[i] == CW'(CPV)) err_q <= 1'b1;
                    else                      cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (iss_hit[i] && !ret_hit[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
        end
    end

    assign flit_valid_out = valid_q;
    assign flit_head_out  = head_q;
    assign flit_tail_out  = tail_q;
    assign flit_sel_ivc   = sel_q;
    assign pkt_done_ivc   = done_q;
    assign error          = err_q;
endmodule

// File: tb/tb_flit_source_sched.sv
// Directed bench for flit_source_sched (8 VCs, 8 credits/VC, payload 1..4).
module tb_flit_source_sched;
    logic        clk, reset;
    logic [7:0]  pkt_req_ivc;
    logic [15:0] pkt_len_ivc;
    logic [3:0]  flow_ctrl_in;
    logic        flit_valid_out, flit_head_out, flit_tail_out, error;
    logic [7:0]  flit_sel_ivc, pkt_done_ivc;
    logic [18:0] ov;

    int nt = 0;
    int nbad = 0;

    flit_source_sched dut (
        .clk(clk), .reset(reset),
        .pkt_req_ivc(pkt_req_ivc), .pkt_len_ivc(pkt_len_ivc),
        .flow_ctrl_in(flow_ctrl_in),
        .flit_valid_out(flit_valid_out), .flit_head_out(flit_head_out),
        .flit_tail_out(flit_tail_out), .flit_sel_ivc(flit_sel_ivc),
        .pkt_done_ivc(pkt_done_ivc), .error(error)
    );

    // {valid, head, tail, sel[7:0], done[7:0]}
    assign ov = {flit_valid_out, flit_head_out, flit_tail_out, flit_sel_ivc, pkt_done_ivc};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nt++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pkt_req_ivc  = '0;
        pkt_len_ivc  = '0;
        flow_ctrl_in = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk_cnts(input string tag, input int exp);
        for (int i = 0; i < 8; i++) chk(tag, 32'(dut.cnt_q[i]), 32'(exp));
    endtask

    function automatic logic [18:0] fv(input logic v, input logic h, input logic t,
                                       input logic [7:0] s, input logic [7:0] d);
        return {v, h, t, s, d};
    endfunction

    initial begin
        int ord[3];
        ord = '{1, 3, 6};
        reset = 1'b1;
        pkt_req_ivc = '0; pkt_len_ivc = '0; flow_ctrl_in = '0;

        // Reset state and idle behaviour
        do_reset();
        chk("rst out", 32'(ov), 32'(0));
        chk("rst err", 32'(error), 32'(0));
        chk_cnts("rst cnt", 8);
        repeat (5) tick();
        chk("idle out", 32'(ov), 32'(0));
        chk_cnts("idle cnt", 8);

        // Single 5-flit packet on VC2; length change mid-packet is ignored
        pkt_req_ivc = 8'h04;
        pkt_len_ivc = 16'h0030;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("vc2 flit", 32'(ov), 32'(fv(1'b1, k == 1, k == 5, 8'h04, (k == 5) ? 8'h04 : 8'h00)));
            if (k == 2) pkt_len_ivc = '0;
            if (k == 5) pkt_req_ivc = '0;
        end
        tick();
        chk("vc2 after", 32'(ov), 32'(0));
        chk("vc2 cnt", 32'(dut.cnt_q[2]), 32'd3);
        repeat (5) begin
            flow_ctrl_in = {3'd2, 1'b1};
            tick();
        end
        flow_ctrl_in = '0;
        tick();
        chk("vc2 refill", 32'(dut.cnt_q[2]), 32'd8);
        chk("vc2 err", 32'(error), 32'd0);

        // Round-robin among VCs 1, 3, 6 with 2-flit packets and bubbles
        do_reset();
        pkt_req_ivc = 8'h4A;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk("rr head", 32'(ov), 32'(fv(1'b1, 1'b1, 1'b0, 8'(1 << ord[p % 3]), 8'h00)));
            tick();
            chk("rr tail", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b1, 8'(1 << ord[p % 3]), 8'(1 << ord[p % 3]))));
            if (p == 5) pkt_req_ivc = '0;
            tick();
            chk("rr bubble", 32'(ov), 32'(0));
        end
        tick();
        chk("rr quiet", 32'(ov), 32'(0));
        chk("rr cnt1", 32'(dut.cnt_q[1]), 32'd4);
        chk("rr cnt3", 32'(dut.cnt_q[3]), 32'd4);
        chk("rr cnt6", 32'(dut.cnt_q[6]), 32'd4);

        // Credit starvation on VC0
        do_reset();
        pkt_req_ivc = 8'h01;
        pkt_len_ivc = 16'h0003;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("st pkt1", 32'(ov), 32'(fv(1'b1, k == 1, k == 5, 8'h01, (k == 5) ? 8'h01 : 8'h00)));
        end
        tick();
        chk("st bubble", 32'(ov), 32'(0));
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("st pkt2", 32'(ov), 32'(fv(1'b1, k == 1, 1'b0, 8'h01, 8'h00)));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st stall", 32'(ov), 32'(0));
        end
        chk("st cnt0", 32'(dut.cnt_q[0]), 32'd0);
        flow_ctrl_in = {3'd0, 1'b1};
        tick();
        flow_ctrl_in = '0;
        chk("st c+1", 32'(ov), 32'(0));
        tick();
        chk("st c+2", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b0, 8'h01, 8'h00)));
        tick();
        chk("st stall2", 32'(ov), 32'(0));
        flow_ctrl_in = {3'd0, 1'b1};
        tick();
        flow_ctrl_in = '0;
        chk("st c2+1", 32'(ov), 32'(0));
        tick();
        chk("st tail", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b1, 8'h01, 8'h01)));
        pkt_req_ivc = '0;
        tick();
        chk("st end", 32'(ov), 32'(0));

        // Simultaneous issue/return, then overflow on a full VC
        do_reset();
        pkt_req_ivc = 8'h10;
        tick();
        chk("ov head", 32'(ov), 32'(fv(1'b1, 1'b1, 1'b0, 8'h10, 8'h00)));
        chk("ov cnt4a", 32'(dut.cnt_q[4]), 32'd7);
        flow_ctrl_in = {3'd4, 1'b1};
        tick();
        flow_ctrl_in = '0;
        pkt_req_ivc = '0;
        chk("ov tail", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b1, 8'h10, 8'h10)));
        chk("ov cnt4b", 32'(dut.cnt_q[4]), 32'd7);
        chk("ov err0", 32'(error), 32'd0);
        flow_ctrl_in = {3'd5, 1'b1};
        tick();
        flow_ctrl_in = '0;
        chk("ov cnt5", 32'(dut.cnt_q[5]), 32'd8);
        chk("ov err1", 32'(error), 32'd1);
        repeat (3) tick();
        chk("ov sticky", 32'(error), 32'd1);

        // Reset in the 3rd flit of a 5-flit packet
        do_reset();
        chk("mr err clr", 32'(error), 32'd0);
        pkt_req_ivc = 8'h80;
        pkt_len_ivc = 16'hC000;
        repeat (3) tick();
        chk("mr flit3", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b0, 8'h80, 8'h00)));
        #2 reset = 1'b1;
        #1;
        chk("mr out", 32'(ov), 32'(0));
        chk_cnts("mr cnt", 8);
        pkt_req_ivc = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mr quiet", 32'(ov), 32'(0));
        end
        pkt_req_ivc = 8'h80;
        pkt_len_ivc = '0;
        tick();
        chk("mr head", 32'(ov), 32'(fv(1'b1, 1'b1, 1'b0, 8'h80, 8'h00)));
        tick();
        pkt_req_ivc = '0;
        chk("mr tail", 32'(ov), 32'(fv(1'b1, 1'b0, 1'b1, 8'h80, 8'h80)));

        $display("test done: total=%0d bad=%0d", nt, nbad);
        $finish;
    end
endmodule
